// File: rtl/mux_scan_pkg.sv
// Shared types and helpers for the registered N:1 scan selector.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mux_scan_pkg;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_MAN  = 2'd1,
        ST_SCAN = 2'd2
    } state_t;

    localparam logic MODE_MAN  = 1'b0;
    localparam logic MODE_SCAN = 1'b1;

    // Index width that never collapses to zero bits, even for n == 1.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mux_scan_sel_mux_n1.sv
// Combinational CHANNELS:1 selector of WIDTH-bit lanes; indices past the last channel give zero.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows inputs continuously.
module mux_n1 #(
    parameter int WIDTH    = 1,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
) (
    input  logic [CHANNELS*WIDTH-1:0] data,
    input  logic [SEL_W-1:0]          sel,
    output logic [WIDTH-1:0]          y
);

    // Pick the lane whose index matches; unmatched (out-of-range) indices leave y at zero.
    always_comb begin
        y = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (int'(sel) == k) begin
                y = data[k*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/mux_scan_sel.sv
// Registered N-channel selector with manual select and dwell-timed auto-scan, plus change/wrap strobes.
// Latency: 1 cycle from Sel/DateIn/Enable/Mode to every output.
// Backpressure: none; consumer must accept DateOut every cycle.
module mux_scan_sel
    import mux_scan_pkg::*;
#(
    parameter int WIDTH    = 1,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = sel_width(CHANNELS),
    parameter int DWELL    = 4
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic [CHANNELS*WIDTH-1:0] DateIn,
    input  logic [SEL_W-1:0]          Sel,
    input  logic                      Enable,
    input  logic                      Mode,
    input  logic                      Hold,
    output logic [WIDTH-1:0]          DateOut,
    output logic [SEL_W-1:0]          CurSel,
    output logic                      ChanStrobe,
    output logic                      Wrap
);

    localparam int              CNT_W    = sel_width(DWELL);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
    localparam logic [SEL_W-1:0] CH_LAST  = SEL_W'(CHANNELS - 1);

    state_t           state_q;
    state_t           nxt_state;
    logic [SEL_W-1:0] cur_q;
    logic [SEL_W-1:0] nxt_cur;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] nxt_cnt;
    logic             nxt_stb;
    logic             nxt_wrap;
    logic [WIDTH-1:0] dout_q;
    logic             stb_q;
    logic             wrap_q;
    logic [WIDTH-1:0] mux_y;

    // The mux is driven by the index being loaded this edge, so DateOut and CurSel always agree.
    mux_n1 #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS),
        .SEL_W    (SEL_W)
    ) u_mux (
        .data (DateIn),
        .sel  (nxt_cur),
        .y    (mux_y)
    );

    // Next-state, next-index, dwell counter and strobe decisions from the live inputs and previous state.
    always_comb begin
        nxt_state = ST_OFF;
        nxt_cur   = cur_q;
        nxt_cnt   = '0;
        nxt_stb   = 1'b0;
        nxt_wrap  = 1'b0;

        if (Enable) begin
            nxt_state = ST_OFF;
        end else if (Mode == MODE_SCAN) begin
            nxt_state = ST_SCAN;
        end else begin
            nxt_state = ST_MAN;
        end

        unique case (nxt_state)
            ST_MAN: begin
                nxt_cur = Sel;
                nxt_stb = (Sel != cur_q);
            end
            ST_SCAN: begin
                if (state_q == ST_MAN) begin
                    // Leaving manual restarts the scan from channel 0.
                    nxt_cur = '0;
                    nxt_stb = (cur_q != '0);
                end else if (state_q == ST_OFF) begin
                    // Re-enabling resumes on the retained channel with a fresh dwell.
                    nxt_cur = cur_q;
                end else if (Hold) begin
                    nxt_cnt = cnt_q;
                end else if (cnt_q == CNT_LAST) begin
                    nxt_cur  = (cur_q == CH_LAST) ? '0 : cur_q + SEL_W'(1);
                    nxt_stb  = 1'b1;
                    nxt_wrap = (cur_q == CH_LAST);
                end else begin
                    nxt_cnt = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                nxt_cur = cur_q;
            end
        endcase
    end

    // State, index, counter and all outputs are registered; reset overrides everything.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= ST_OFF;
            cur_q   <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
            stb_q   <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= nxt_state;
            cur_q   <= nxt_cur;
            cnt_q   <= nxt_cnt;
            dout_q  <= (nxt_state == ST_OFF) ? '0 : mux_y;
            stb_q   <= nxt_stb;
            wrap_q  <= nxt_wrap;
        end
    end

    assign DateOut    = dout_q;
    assign CurSel     = cur_q;
    assign ChanStrobe = stb_q;
    assign Wrap       = wrap_q;

endmodule

// File: tb/tb_mux_scan_sel.sv
// Directed bench for mux_scan_sel: 4-channel/DWELL=3 vector table plus a 3-channel out-of-range and wrap sequence.
// Latency: outputs checked 1 ns after each rising edge.
// Backpressure: n/a.
module tb_mux_scan_sel;

    localparam logic [31:0] D0 = 32'hD3C2B1A0;
    localparam logic [31:0] DH = 32'hD355B1A0;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic [31:0] DateIn = D0;
    logic [1:0]  Sel = 2'd0;
    logic        Enable = 1'b0;
    logic        Mode = 1'b1;
    logic        Hold = 1'b0;
    logic [7:0]  DateOut;
    logic [1:0]  CurSel;
    logic        ChanStrobe;
    logic        Wrap;

    logic        Rst3 = 1'b1;
    logic [23:0] DateIn3 = 24'hC2B1A0;
    logic [1:0]  Sel3 = 2'd0;
    logic        Enable3 = 1'b0;
    logic        Mode3 = 1'b0;
    logic        Hold3 = 1'b0;
    logic [7:0]  DateOut3;
    logic [1:0]  CurSel3;
    logic        ChanStrobe3;
    logic        Wrap3;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    mux_scan_sel #(.WIDTH(8), .CHANNELS(4), .DWELL(3)) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .DateIn     (DateIn),
        .Sel        (Sel),
        .Enable     (Enable),
        .Mode       (Mode),
        .Hold       (Hold),
        .DateOut    (DateOut),
        .CurSel     (CurSel),
        .ChanStrobe (ChanStrobe),
        .Wrap       (Wrap)
    );

    mux_scan_sel #(.WIDTH(8), .CHANNELS(3), .DWELL(3)) dut3 (
        .Clk        (Clk),
        .Rst        (Rst3),
        .DateIn     (DateIn3),
        .Sel        (Sel3),
        .Enable     (Enable3),
        .Mode       (Mode3),
        .Hold       (Hold3),
        .DateOut    (DateOut3),
        .CurSel     (CurSel3),
        .ChanStrobe (ChanStrobe3),
        .Wrap       (Wrap3)
    );

    typedef struct {
        logic        rst;
        logic        en;
        logic        mode;
        logic        hold;
        logic [1:0]  sel;
        logic [31:0] din;
        logic [7:0]  dout;
        logic [1:0]  cur;
        logic        stb;
        logic        wrp;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic rst, input logic en, input logic mode, input logic hold,
                       input logic [1:0] sel, input logic [31:0] din,
                       input logic [7:0] dout, input logic [1:0] cur,
                       input logic stb, input logic wrp);
        vec_t v;
        v.rst = rst; v.en = en; v.mode = mode; v.hold = hold; v.sel = sel; v.din = din;
        v.dout = dout; v.cur = cur; v.stb = stb; v.wrp = wrp;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    initial begin
        logic [7:0]  b;
        logic [31:0] dsh;

        // Reset with scan requested, then first sample after release.
        add(1, 0, 1, 0, 0, D0, 8'h00, 0, 0, 0);
        add(1, 0, 1, 0, 0, D0, 8'h00, 0, 0, 0);
        add(0, 0, 1, 0, 0, D0, 8'hA0, 0, 0, 0);
        // Manual select 0 -> 2, then held.
        add(0, 0, 0, 0, 0, D0, 8'hA0, 0, 0, 0);
        add(0, 0, 0, 0, 2, D0, 8'hC2, 2, 1, 0);
        add(0, 0, 0, 0, 2, D0, 8'hC2, 2, 0, 0);
        add(0, 0, 0, 0, 2, D0, 8'hC2, 2, 0, 0);
        // Scan: 3 cycles per channel, strobe on each step (first from MAN exit with CurSel=2), wrap at 3->0.
        for (int e = 0; e < 19; e++) begin
            dsh = D0 >> (8 * ((e / 3) % 4));
            b = dsh[7:0];
            add(0, 0, 1, 0, 0, D0, b, 2'((e / 3) % 4), (e % 3) == 0, e == 12);
        end
        // Hold on channel 2 with ch2 changed to 0x55.
        for (int e = 0; e < 5; e++) add(0, 0, 1, 1, 0, DH, 8'h55, 2, 0, 0);
        add(0, 0, 1, 0, 0, DH, 8'h55, 2, 0, 0);
        add(0, 0, 1, 0, 0, DH, 8'h55, 2, 0, 0);
        add(0, 0, 1, 0, 0, DH, 8'hD3, 3, 1, 0);
        add(0, 0, 1, 0, 0, DH, 8'hD3, 3, 0, 0);
        add(0, 0, 1, 0, 0, DH, 8'hD3, 3, 0, 0);
        add(0, 0, 1, 0, 0, DH, 8'hA0, 0, 1, 1);
        add(0, 0, 1, 0, 0, DH, 8'hA0, 0, 0, 0);
        add(0, 0, 1, 0, 0, DH, 8'hA0, 0, 0, 0);
        add(0, 0, 1, 0, 0, DH, 8'hB1, 1, 1, 0);
        add(0, 0, 1, 0, 0, DH, 8'hB1, 1, 0, 0);
        // Disable on channel 1, then re-enable with a full dwell.
        add(0, 1, 1, 0, 0, D0, 8'h00, 1, 0, 0);
        add(0, 1, 1, 0, 0, D0, 8'h00, 1, 0, 0);
        add(0, 0, 1, 0, 0, D0, 8'hB1, 1, 0, 0);
        add(0, 0, 1, 0, 0, D0, 8'hB1, 1, 0, 0);
        add(0, 0, 1, 0, 0, D0, 8'hB1, 1, 0, 0);
        add(0, 0, 1, 0, 0, D0, 8'hC2, 2, 1, 0);
        add(0, 0, 1, 0, 0, D0, 8'hC2, 2, 0, 0);
        add(0, 0, 1, 0, 0, D0, 8'hC2, 2, 0, 0);
        add(0, 0, 1, 0, 0, D0, 8'hD3, 3, 1, 0);
        add(0, 0, 1, 0, 0, D0, 8'hD3, 3, 0, 0);
        // Reset mid-dwell on channel 3, then scan restarts from channel 0.
        add(1, 0, 1, 0, 0, D0, 8'h00, 0, 0, 0);
        add(0, 0, 1, 0, 0, D0, 8'hA0, 0, 0, 0);

        foreach (vq[i]) begin
            @(negedge Clk);
            Rst = vq[i].rst; Enable = vq[i].en; Mode = vq[i].mode;
            Hold = vq[i].hold; Sel = vq[i].sel; DateIn = vq[i].din;
            @(posedge Clk);
            #1;
            chk("DateOut", i, 32'(DateOut), 32'(vq[i].dout));
            chk("CurSel", i, 32'(CurSel), 32'(vq[i].cur));
            chk("ChanStrobe", i, 32'(ChanStrobe), 32'(vq[i].stb));
            chk("Wrap", i, 32'(Wrap), 32'(vq[i].wrp));
        end

        // Three-channel instance: out-of-range manual select and wrap at 2->0.
        @(negedge Clk);
        Rst3 = 1'b1; Enable3 = 1'b0; Mode3 = 1'b0; Sel3 = 2'd3;
        @(posedge Clk); #1;
        chk("c3_rst_DateOut", 0, 32'(DateOut3), 32'h00);
        chk("c3_rst_CurSel", 0, 32'(CurSel3), 32'd0);
        @(negedge Clk);
        Rst3 = 1'b0;
        @(posedge Clk); #1;
        chk("c3_oor_DateOut", 1, 32'(DateOut3), 32'h00);
        chk("c3_oor_CurSel", 1, 32'(CurSel3), 32'd3);
        chk("c3_oor_ChanStrobe", 1, 32'(ChanStrobe3), 32'd1);
        @(negedge Clk);
        Sel3 = 2'd1;
        @(posedge Clk); #1;
        chk("c3_man_DateOut", 2, 32'(DateOut3), 32'hB1);
        chk("c3_man_CurSel", 2, 32'(CurSel3), 32'd1);
        @(negedge Clk);
        Mode3 = 1'b1;
        for (int e = 0; e < 10; e++) begin
            @(posedge Clk); #1;
            dsh = 32'(DateIn3) >> (8 * ((e / 3) % 3));
            b = dsh[7:0];
            chk("c3_scan_CurSel", e, 32'(CurSel3), (e / 3) % 3);
            chk("c3_scan_DateOut", e, 32'(DateOut3), 32'(b));
            chk("c3_scan_ChanStrobe", e, 32'(ChanStrobe3), 32'((e % 3) == 0));
            chk("c3_scan_Wrap", e, 32'(Wrap3), 32'(e == 9));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
